tiny_comp_mc: RTL
=================

# tiny_comp_mc

Parametrised, single-clock, multi-cycle successor to the team's two-phase 32-bit tiny computer. It keeps the same 32-bit instruction format and ALU/rotate/skip semantics. Additions over the two-phase design: a configurable memory depth, a ready/valid output channel with backpressure, an input stall that waits for data, and an optional HALT opcode. It sits as the control/compute core beside the I/O shell and replaces the Ph0/Ph1 scheme with one clock and an explicit state machine.

## Interface
- PC_W, 10, PC and address width; instruction and data memories each hold 2^PC_W × 32-bit words (4 ≤ PC_W ≤ 16).
- RF_AW, 7, register-file address width (1 ≤ RF_AW ≤ 7); only the low RF_AW bits of each 7-bit register field are used.
- INIT_FILE, "", hex image loaded into instruction memory at elaboration; no load when empty.
- Ph0  in  1  sole clock; all state updates on the rising edge.
- ResetN  in  1  reset, asynchronous, active-low.
- InData  in  32  input port data.
- InRdy  in  1  input data available.
- InStrobe  out  1  one-cycle pulse; InData consumed this cycle.
- OutData  out  32  output port data, registered.
- OutValid  out  1  OutData valid; held until accepted.
- OutRdy  in  1  consumer accepts OutData when OutValid & OutRdy.
- Halted  out  1  core stopped on HALT.
- DbgPC  out  PC_W  current PC.

## Operation
- Instruction fields:
  - IR[31:25] Rw, IR[24] const, IR[23:17] Ra, IR[16:10] Rb.
  - IR[9:7] function: 0 A+B, 1 A−B, 2 B+1, 3 B−1, 4 A&B, 5 A|B, 7 A^B, 6 yields 0.
  - IR[6:5] rotate right by 0/1/8/16, applied to the function result.
  - IR[4:3] skip: 0 none, 1 ALU[31], 2 ALU==0, 3 InRdy.
  - IR[2:0] op.
- Constant (IR[24]=1): Rw ← {8'b0, IR[23:0]}. Function, rotate, skip and op fields are ignored; PC ← PC+1.
- Ops when IR[24]=0:
  - 0 Rw←ALU.
  - 1 IMEM[B]←A, Rw←ALU.
  - 2 DMEM[B]←A, Rw←ALU.
  - 3 OutData←A, Rw←ALU.
  - 4 Rw←DMEM[B].
  - 5 Rw←InData.
  - 6 Rw←{0,PC+1}, PC←ALU[PC_W-1:0].
  - 7 HALT (see Configuration).
- Memory addresses use B[PC_W-1:0]. PC arithmetic is modulo 2^PC_W: PC+1 and PC+2 wrap silently.
- Register file writes always occur at EXEC completion, except HALT and reset-aborted instructions. R0 is an ordinary register. Register file contents are undefined after reset.
- Skip condition true: PC←PC+2; otherwise PC+1. Jump overrides skip.
- FSM states: FETCH, DECODE, EXEC, MEM, HALT.
  - FETCH: synchronous IMEM read at PC → DECODE.
  - DECODE: IR latched; RF reads Ra, Rb → EXEC.
  - EXEC, op 4: DMEM read at B → MEM.
  - EXEC, op 5 with InRdy=0: stay in EXEC.
  - EXEC, op 3 with OutValid=1 and OutRdy=0: stay in EXEC (previous output not yet drained).
  - EXEC, otherwise: commit → FETCH.
  - MEM: write Rw, update PC → FETCH.
- Output channel: OutValid sets at op 3 commit and clears on the OutValid&OutRdy handshake. A commit and a handshake in the same cycle leave OutValid=1 carrying the new data.

## Timing
- Reset values: PC 0, state FETCH, InStrobe 0, OutValid 0, OutData 0, Halted 0, DbgPC 0.
- Reset asserted mid-instruction aborts it: no RF, IMEM or DMEM write, and no strobe.
- Latency: 3 cycles per instruction; 4 for op 4; op 5 adds 1 cycle per cycle of InRdy=0.
- InStrobe is high exactly in the EXEC cycle where op 5 commits with InRdy=1.
- Skip on InRdy samples InRdy in the EXEC cycle.
- Memory writes land at the commit edge. A write to the instruction being executed takes effect on the next fetch of that address.
- Write-then-read of the same register in consecutive instructions is coherent, because the RF is read in DECODE after the previous commit.

## Configuration
- TINY_COMP_MC_HALT_EN defined:
  - op 7 enters HALT with no register write.
  - Halted=1 and PC stays frozen.
  - Only reset leaves HALT.
- Undefined:
  - op 7 is a no-op: Rw←0, PC+1.
  - Halted is tied 0.

## Test plan
- Constant and ADD:
  - Stimulus: R1←5, R2←7, then R3←R1+R2 with rotate 0.
  - Response: R3=12 after 9 cycles; DbgPC=3.
- Skip and jump:
  - Stimulus: R1←0, then skip-on-zero of B−1 with B=R1.
  - Response: ALU=0xFFFFFFFF, ALU[31]=1, no skip, PC+1.
  - Stimulus: op 6 with ALU=0x3FF, PC_W=10.
  - Response: PC=0x3FF, link register holds old PC+1.
  - Stimulus: PC+1 at PC=0x3FF.
  - Response: PC wraps to 0.
- Input stall:
  - Stimulus: op 5 with InRdy low for 4 cycles, then InRdy=1, InData=0xDEADBEEF.
  - Response: one InStrobe pulse; Rw=0xDEADBEEF; instruction takes 7 cycles.
- Output backpressure:
  - Stimulus: two back-to-back op 3 with A=0x11 then 0x22; OutRdy held low 10 cycles.
  - Response: second instruction stalls in EXEC; OutData stays 0x11 until handshake, then becomes 0x22.
- Memory:
  - Stimulus: op 2 DMEM[0x40]←0xCAFE, then op 4 from 0x40.
  - Response: Rw=0xCAFE; op 4 takes 4 cycles.
- HALT and reset:
  - Stimulus: op 7 with the macro defined.
  - Response: Halted=1 and PC frozen for 100 cycles.
  - Stimulus: ResetN low asynchronously.
  - Response: all outputs return to reset values and execution restarts at PC 0.

Source files
------------

// File: rtl/tiny_comp_mc.sv
// tiny_comp_mc -- single-clock multi-cycle 32-bit tiny computer core.
module tiny_comp_mc #(
  parameter int PC_W      = 10,
  parameter int RF_AW     = 7,
  parameter     INIT_FILE = ""
) (
  input  logic            Ph0,
  input  logic            ResetN,
  input  logic [31:0]     InData,
  input  logic            InRdy,
  output logic            InStrobe,
  output logic [31:0]     OutData,
  output logic            OutValid,
  input  logic            OutRdy,
  output logic            Halted,
  output logic [PC_W-1:0] DbgPC
);

  localparam int DEPTH = 1 << PC_W;
  localparam int RF_N  = 1 << RF_AW;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_t;

  state_t r_state, w_state_nxt;

  logic [31:0] r_imem [DEPTH];
  logic [31:0] r_dmem [DEPTH];
  logic [31:0] r_rf   [RF_N];

  logic [31:0]     r_ir, r_a, r_b, r_mdata;
  logic [PC_W-1:0] r_pc, w_pc_nxt;
  logic            r_skip_q;
  logic [31:0]     r_out_data;
  logic            r_out_valid;

  logic [RF_AW-1:0] w_rw, w_ra, w_rb;
  logic             w_const;
  logic [2:0]       w_fn, w_op;
  logic [1:0]       w_rot, w_skip;
  logic [PC_W-1:0]  w_addr, w_pc_inc1, w_pc_inc2, w_pc_seq;

  assign w_rw      = r_ir[25 +: RF_AW];
  assign w_ra      = r_ir[17 +: RF_AW];
  assign w_rb      = r_ir[10 +: RF_AW];
  assign w_const   = r_ir[24];
  assign w_fn      = r_ir[9:7];
  assign w_rot     = r_ir[6:5];
  assign w_skip    = r_ir[4:3];
  assign w_op      = r_ir[2:0];
  assign w_addr    = r_b[PC_W-1:0];
  assign w_pc_inc1 = r_pc + PC_W'(1);
  assign w_pc_inc2 = r_pc + PC_W'(2);

  logic [31:0] w_fres, w_alu;
  logic        w_skip_cond;

  always_comb begin
    w_fres = '0;
    case (w_fn)
      3'd0:    w_fres = r_a + r_b;
      3'd1:    w_fres = r_a - r_b;
      3'd2:    w_fres = r_b + 32'd1;
      3'd3:    w_fres = r_b - 32'd1;
      3'd4:    w_fres = r_a & r_b;
      3'd5:    w_fres = r_a | r_b;
      3'd7:    w_fres = r_a ^ r_b;
      default: w_fres = '0;
    endcase
    case (w_rot)
      2'd0:    w_alu = w_fres;
      2'd1:    w_alu = {w_fres[0],    w_fres[31:1]};
      2'd2:    w_alu = {w_fres[7:0],  w_fres[31:8]};
      default: w_alu = {w_fres[15:0], w_fres[31:16]};
    endcase
    case (w_skip)
      2'd0:    w_skip_cond = 1'b0;
      2'd1:    w_skip_cond = w_alu[31];
      2'd2:    w_skip_cond = (w_alu == '0);
      default: w_skip_cond = InRdy;
    endcase
  end

  assign w_pc_seq = w_skip_cond ? w_pc_inc2 : w_pc_inc1;

  logic        w_rf_we, w_imem_we, w_dmem_we, w_out_load, w_strobe;
  logic [31:0] w_rf_wd;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_rf_we     = 1'b0;
    w_rf_wd     = '0;
    w_imem_we   = 1'b0;
    w_dmem_we   = 1'b0;
    w_out_load  = 1'b0;
    w_strobe    = 1'b0;
    case (r_state)
      S_FETCH:  w_state_nxt = S_DECODE;
      S_DECODE: w_state_nxt = S_EXEC;
      S_EXEC: begin
        if (w_const) begin
          w_rf_we     = 1'b1;
          w_rf_wd     = {8'h00, r_ir[23:0]};
          w_pc_nxt    = w_pc_inc1;
          w_state_nxt = S_FETCH;
        end else begin
          case (w_op)
            3'd0, 3'd1, 3'd2: begin
              w_rf_we     = 1'b1;
              w_rf_wd     = w_alu;
              w_imem_we   = (w_op == 3'd1);
              w_dmem_we   = (w_op == 3'd2);
              w_pc_nxt    = w_pc_seq;
              w_state_nxt = S_FETCH;
            end
            3'd3: begin
              if (!(r_out_valid && !OutRdy)) begin
                w_out_load  = 1'b1;
                w_rf_we     = 1'b1;
                w_rf_wd     = w_alu;
                w_pc_nxt    = w_pc_seq;
                w_state_nxt = S_FETCH;
              end
            end
            3'd4: w_state_nxt = S_MEM;
            3'd5: begin
              if (InRdy) begin
                w_strobe    = 1'b1;
                w_rf_we     = 1'b1;
                w_rf_wd     = InData;
                w_pc_nxt    = w_pc_seq;
                w_state_nxt = S_FETCH;
              end
            end
            3'd6: begin
              w_rf_we           = 1'b1;
              w_rf_wd[PC_W-1:0] = w_pc_inc1;
              w_pc_nxt          = w_alu[PC_W-1:0];
              w_state_nxt       = S_FETCH;
            end
            default: begin
`ifdef TINY_COMP_MC_HALT_EN
              w_state_nxt = S_HALT;
`else
              w_rf_we     = 1'b1;
              w_pc_nxt    = w_pc_inc1;
              w_state_nxt = S_FETCH;
`endif
            end
          endcase
        end
      end
      S_MEM: begin
        // Skip decision was captured in EXEC so InRdy skips sample there
        w_rf_we     = 1'b1;
        w_rf_wd     = r_mdata;
        w_pc_nxt    = r_skip_q ? w_pc_inc2 : w_pc_inc1;
        w_state_nxt = S_FETCH;
      end
      default: w_state_nxt = r_state;
    endcase
  end

  always_ff @(posedge Ph0 or negedge ResetN) begin
    if (!ResetN) begin
      r_state     <= S_FETCH;
      r_pc        <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_out_load) begin
        r_out_data  <= r_a;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && OutRdy) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // Writes are gated by the FSM, which reset forces to FETCH, so an
  // aborted instruction never writes.
  always_ff @(posedge Ph0) begin
    if (r_state == S_FETCH) r_ir <= r_imem[r_pc];
    if (r_state == S_DECODE) begin
      r_a <= r_rf[w_ra];
      r_b <= r_rf[w_rb];
    end
    if (r_state == S_EXEC) r_skip_q <= w_skip_cond;
    r_mdata <= r_dmem[w_addr];
    if (w_rf_we)   r_rf[w_rw]     <= w_rf_wd;
    if (w_imem_we) r_imem[w_addr] <= r_a;
    if (w_dmem_we) r_dmem[w_addr] <= r_a;
  end

  assign InStrobe = w_strobe;
  assign OutData  = r_out_data;
  assign OutValid = r_out_valid;
  assign DbgPC    = r_pc;
`ifdef TINY_COMP_MC_HALT_EN
  assign Halted   = (r_state == S_HALT);
`else
  assign Halted   = 1'b0;
`endif

endmodule
